// File: rtl/multi_cycle_control_fsm.sv
// Main sequencer for the multi-cycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
// Optional performance counters are built when PERF_CNT_EN is defined.
module multi_cycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr,
  output logic [3:0] state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  // state | meaning
  // IDLE     | held in reset, first clk after release goes to FETCH
  // FETCH    | read instruction at PC, PC <= PC+4 when memory answers
  // DECODE   | precompute branch target (old PC + imm), dispatch on op
  // MEMADR   | rs1 + imm for lw/sw
  // MEMREAD  | load request, wait for mem_ready
  // MEMWB    | rd <= memory data
  // MEMWRITE | store request, wait for mem_ready
  // EXEC_R   | rs1 op rs2
  // EXEC_I   | rs1 op imm
  // ALUWB    | rd <= ALUOut
  // BEQ      | rs1 - rs2, take branch on zero
  // JAL      | PC <= target, then rd <= PC+4 via ALUWB
  // ILLEGAL  | unsupported opcode, parked until reset
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t state_q, state_next;
  logic [2:0] funct_alu;

  // Unsupported funct3 values fall back to add rather than trapping.
  always_comb begin
    funct_alu = 3'b000;
    case (funct3)
      3'b000:  funct_alu = (op[5] & funct7_5) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_next;
  end

  always_comb begin
    state_next    = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    imm_src       = 2'b00;
    alu_control   = 3'b000;
    illegal_instr = 1'b0;

    if (state_q != S_IDLE && state_q != S_ILLEGAL) begin
      case (op)
        OP_SW:   imm_src = 2'b01;
        OP_BEQ:  imm_src = 2'b10;
        OP_JAL:  imm_src = 2'b11;
        default: imm_src = 2'b00;
      endcase
    end

    case (state_q)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = funct_alu;
        state_next  = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write    = zero_flag;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default:   state_next = S_FETCH;
    endcase
  end

  assign state = state_q;

`ifdef PERF_CNT_EN
  // A FETCH->FETCH stall is not a retirement; only re-entry into FETCH counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_IDLE) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state_q != S_IDLE && state_q != S_FETCH && state_next == S_FETCH)
        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Directed bench for multi_cycle_control_fsm; expected control words are hand-computed per state.
// Counter checks are compiled in when PERF_CNT_EN is defined.
module tb_multi_cycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       funct7_5 = 1'b0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       illegal_instr;
  logic [3:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  multi_cycle_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control),
    .illegal_instr(illegal_instr), .state(state)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs {state,mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,result_src,a,b,imm,alu,illegal}.
  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic mreq, input logic mw, input logic adr,
                     input logic irw, input logic pcw, input logic rw,
                     input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                     input logic [1:0] imm, input logic [2:0] alu, input logic ill);
    logic [31:0] got, exp;
    #1;
    got = {10'b0, state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};
    exp = {10'b0, st, mreq, mw, adr, irw, pcw, rw, rs, a, b, imm, alu, ill};
    check_val(tag, got, exp);
  endtask

  // Assumes state is FETCH with mem_ready=1; leaves the FSM one tick past DECODE.
  task automatic fetch_decode(input string tag, input logic [1:0] imm);
    cyc({tag, "_fetch"},  4'd1, 1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    tick();
    cyc({tag, "_decode"}, 4'd2, 0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
    tick();
  endtask

  logic [2:0] f3_tab  [5] = '{3'b111, 3'b110, 3'b010, 3'b001, 3'b000};
  logic       f75_tab [5] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
  logic [2:0] alu_tab [5] = '{3'b010, 3'b011, 3'b101, 3'b000, 3'b000};

  initial begin
    #2;
    cyc("reset", 4'd0, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b0;
    rst = 1'b1;
    tick();
    cyc("fetch_stall1", 4'd1, 1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    tick();
    cyc("fetch_stall2", 4'd1, 1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
    mem_ready = 1'b1;

    // add x3,x1,x2
    fetch_decode("add", 2'b00);
    cyc("add_exec",  4'd7, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0);
    tick();
    cyc("add_aluwb", 4'd9, 0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    tick();

    // sub: op[5]=1 and funct7_5=1
    funct7_5 = 1'b1;
    fetch_decode("sub", 2'b00);
    cyc("sub_exec", 4'd7, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0);
    tick(); tick();

    // I-type funct decode: and, or, slt, unsupported funct3, funct7_5 ignored
    op = 7'b0010011;
    for (int i = 0; i < 5; i++) begin
      funct3 = f3_tab[i]; funct7_5 = f75_tab[i];
      fetch_decode("alui", 2'b00);
      cyc("alui_exec", 4'd8, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, alu_tab[i], 0);
      tick(); tick();
    end
    funct3 = 3'b010; funct7_5 = 1'b0;

    // lw with three stalled cycles in MEMREAD
    op = 7'b0000011;
    fetch_decode("lw", 2'b00);
    cyc("lw_memadr", 4'd3, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc("lw_memread", 4'd4, 1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    end
    mem_ready = 1'b1;
    tick();
    cyc("lw_memwb", 4'd5, 0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    tick();

    // beq taken then not taken
    op = 7'b1100011;
    zero_flag = 1'b1;
    fetch_decode("beq_t", 2'b10);
    cyc("beq_taken", 4'd10, 0,0,0,0,1,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
    tick();
    zero_flag = 1'b0;
    fetch_decode("beq_n", 2'b10);
    cyc("beq_not", 4'd10, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0);
    tick();

    // jal
    op = 7'b1101111;
    fetch_decode("jal", 2'b11);
    cyc("jal_jal",   4'd11, 0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0);
    tick();
    cyc("jal_aluwb", 4'd9,  0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0);
    tick();
    cyc("jal_back",  4'd1,  1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0);

    // sw held in MEMWRITE, then async reset
    op = 7'b0100011;
    fetch_decode("sw", 2'b01);
    cyc("sw_memadr", 4'd3, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0);
    mem_ready = 1'b0;
    tick();
    cyc("sw_memwrite", 4'd6, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0);
    #2 rst = 1'b0;
    cyc("sw_async_rst", 4'd0, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    mem_ready = 1'b1;
    tick();
    cyc("rst_held", 4'd0, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    rst = 1'b1;
    tick();
    cyc("rst_release", 4'd1, 1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0);

    // unsupported opcode parks in ILLEGAL
    op = 7'b1111111;
    fetch_decode("ill", 2'b00);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      cyc("illegal_hold", 4'd12, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1);
      tick();
    end
    rst = 1'b0;
    cyc("illegal_clr", 4'd0, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);

`ifdef PERF_CNT_EN
    check_val("cnt_rst_cycle", cycle_cnt, 32'd0);
    check_val("cnt_rst_inst",  instret_cnt, 32'd0);
    op = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) tick();
    check_val("cnt_state", {28'b0, state}, 32'd1);
    check_val("cnt_cycle", cycle_cnt, 32'd12);
    check_val("cnt_inst",  instret_cnt, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
